// File: rtl/shift_add_sequencer_if.sv
// Handshake and shift-register bus for shift_add_sequencer.
// The master is the requester plus the external left-shift register; the sequencer is the slave.
interface shift_add_sequencer_if #(
    parameter int DW = 16
);
    localparam int DW_2 = 2 * DW;

    logic            start;
    logic [DW-1:0]   multiplier;
    logic [DW-1:0]   multiplicand;
    logic [DW_2-1:0] shift_in;
    logic [DW_2-1:0] load_value;
    logic            l_s;
    logic            permit;
    logic            busy;
    logic            done;
    logic [DW_2-1:0] product;

    modport master (
        output start, multiplier, multiplicand, shift_in,
        input  load_value, l_s, permit, busy, done, product
    );

    modport slave (
        input  start, multiplier, multiplicand, shift_in,
        output load_value, l_s, permit, busy, done, product
    );
endinterface

// File: rtl/shift_add_sequencer.sv
// Sequential shift-add multiplier control/accumulate stage, fed by an external left-shift register.
// Optional macro SHIFT_ADD_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module shift_add_sequencer #(
    parameter int DW    = 16,
    parameter int CNT_W = $clog2(DW + 1)
) (
    input logic                  clk,
    input logic                  rst,
    shift_add_sequencer_if.slave bus
);
    localparam int DW_2 = 2 * DW;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mplr_q;
    logic [DW-1:0]   mcnd_q;
    logic [DW_2-1:0] acc_q;
    logic [DW_2-1:0] product_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW_2-1:0] sum;
    logic            run_last;
    logic            l_s, permit, busy, done;

    // Sum including the current addend; also the product value on the exit edge.
    assign sum = mplr_q[0] ? (acc_q + bus.shift_in) : acc_q;

`ifdef SHIFT_ADD_EARLY_EXIT_EN
    assign run_last = (cnt_q == CNT_W'(DW - 1)) || (mplr_q[DW-1:1] == '0);
`else
    assign run_last = (cnt_q == CNT_W'(DW - 1));
`endif

    always_comb begin
        state_d = state_q;
        l_s     = 1'b0;
        permit  = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                l_s     = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                permit = 1'b0;
                if (run_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mplr_q    <= '0;
            mcnd_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mplr_q <= bus.multiplier;
                        mcnd_q <= bus.multiplicand;
                    end
                end
                LOAD: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                RUN: begin
                    acc_q  <= sum;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (run_last) product_q <= sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.load_value = {{DW{1'b0}}, mcnd_q};
    assign bus.l_s        = l_s;
    assign bus.permit     = permit;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.product    = product_q;
endmodule

// File: tb/tb_shift_add_sequencer.sv
// Self-checking bench for shift_add_sequencer with a behavioural left-shift register and product model.
module tb_shift_add_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    shift_add_sequencer_if #(.DW(DW)) bus ();

    shift_add_sequencer #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural left-shift multiplicand register driven by the sequencer's controls.
    logic [2*DW-1:0] sreg;
    always @(posedge clk) begin
        if (rst)                sreg <= '0;
        else if (bus.l_s)       sreg <= bus.load_value;
        else if (!bus.permit)   sreg <= sreg << 1;
    end
    assign bus.shift_in = sreg;

    function automatic int exp_run_len(input logic [DW-1:0] m);
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        int hi;
        hi = -1;
        for (int i = 0; i < DW; i++) if (m[i]) hi = i;
        return (hi < 0) ? 1 : hi + 1;
`else
        return DW;
`endif
    endfunction

    function automatic logic [2*DW-1:0] exp_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[2*DW-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplier = '0;
        bus.multiplicand = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.l_s !== 1'b0) begin failures++; $display("FAIL reset_l_s got=%b exp=0", bus.l_s); end
        checks++; if (bus.permit !== 1'b1) begin failures++; $display("FAIL reset_permit got=%b exp=1", bus.permit); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", bus.product); end
        checks++; if (bus.load_value !== '0) begin failures++; $display("FAIL reset_load_value got=%h exp=0", bus.load_value); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    endtask

    // One full multiply with cycle-exact control checks; operands are scrambled after acceptance.
    task automatic run_mult(input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
        int rl;
        logic [2*DW-1:0] ep;
        rl = exp_run_len(a);
        ep = exp_prod(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplier = a;
        bus.multiplicand = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.multiplier = DW'($urandom);
        bus.multiplicand = DW'($urandom);
        for (int c = 1; c <= rl + 2; c++) begin
            if (c > 1) @(negedge clk);
            checks++; if (bus.l_s !== (c == 1)) begin failures++; $display("FAIL %s_l_s cycle=%0d got=%b exp=%b", tag, c, bus.l_s, (c == 1)); end
            checks++; if (bus.permit !== !(c >= 2 && c <= rl + 1)) begin failures++; $display("FAIL %s_permit cycle=%0d got=%b", tag, c, bus.permit); end
            checks++; if (bus.done !== (c == rl + 2)) begin failures++; $display("FAIL %s_done cycle=%0d got=%b", tag, c, bus.done); end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s_busy cycle=%0d got=%b exp=1", tag, c, bus.busy); end
        end
        checks++; if (bus.product !== ep) begin failures++; $display("FAIL %s_product got=%h exp=%h", tag, bus.product, ep); end
        repeat (2) @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL %s_after got done=%b busy=%b exp 0 0", tag, bus.done, bus.busy); end
        checks++; if (bus.product !== ep) begin failures++; $display("FAIL %s_hold got=%h exp=%h", tag, bus.product, ep); end
    endtask

    task automatic test_basic();
        run_mult(16'd3, 16'd5, "basic");
        checks++; if (bus.product !== 32'h0000000F) begin failures++; $display("FAIL basic_const got=%h exp=0000000f", bus.product); end
    endtask

    task automatic test_max();
        run_mult(16'hFFFF, 16'hFFFF, "max");
        checks++; if (bus.product !== 32'hFFFE0001) begin failures++; $display("FAIL max_const got=%h exp=fffe0001", bus.product); end
    endtask

    task automatic test_zero();
        run_mult(16'h0000, 16'h1234, "zero");
        run_mult(16'h1234, 16'h0000, "zero_mcnd");
    endtask

    task automatic test_early_exit();
        run_mult(16'd5, 16'd9, "small5x9");
        checks++; if (bus.product !== 32'd45) begin failures++; $display("FAIL small_const got=%h exp=0000002d", bus.product); end
        run_mult(16'd1, 16'hBEEF, "one");
        run_mult(16'h8000, 16'h0003, "topbit");
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
            b = DW'($urandom);
            run_mult(a, b, "rand");
        end
    endtask

    task automatic test_start_while_busy();
        int rl, inj;
        bit seen;
        rl = exp_run_len(16'd3);
        inj = (rl + 2 < 5) ? rl + 2 : 5;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplier = 16'd3; bus.multiplicand = 16'd5;
        for (int c = 1; c <= rl + 2; c++) begin
            @(negedge clk);
            if (c == inj) begin
                bus.start = 1'b1; bus.multiplier = 16'd7; bus.multiplicand = 16'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                checks++; if (bus.product !== 32'd15) begin failures++; $display("FAIL busy_start_product got=%h exp=0000000f", bus.product); end
                checks++; if (c != rl + 2) begin failures++; $display("FAIL busy_start_latency got=%0d exp=%0d", c, rl + 2); end
            end
        end
        bus.start = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL busy_start_done got=none exp=pulse"); end
        for (int c = 0; c < DW + 4; c++) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued cycle=%0d done=%b busy=%b exp 0 0", c, bus.done, bus.busy); end
        end
        run_mult(16'd7, 16'd7, "after_busy");
        checks++; if (bus.product !== 32'd49) begin failures++; $display("FAIL after_busy_const got=%h exp=00000031", bus.product); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        int rl, gap, first;
        a = DW'($urandom);
        b = DW'($urandom);
        rl = exp_run_len(a);
        first = -1;
        gap = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplier = a; bus.multiplicand = b;
        for (int c = 1; c <= 2 * (DW + 3) + 2; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                checks++; if (bus.product !== exp_prod(a, b)) begin failures++; $display("FAIL b2b_product got=%h exp=%h", bus.product, exp_prod(a, b)); end
                if (first < 0) first = c;
                else if (gap < 0) begin
                    gap = c - first;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (first != rl + 2) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", first, rl + 2); end
        checks++; if (gap != rl + 3) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", gap, rl + 3); end
        repeat (DW + 4) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] a;
        a = DW'($urandom) | 16'h8000;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplier = a; bus.multiplicand = DW'($urandom) | 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        checks++; if (bus.product !== '0) begin failures++; $display("FAIL midrst_product got=%h exp=0", bus.product); end
        checks++; if (bus.permit !== 1'b1) begin failures++; $display("FAIL midrst_permit got=%b exp=1", bus.permit); end
        checks++; if (bus.l_s !== 1'b0) begin failures++; $display("FAIL midrst_l_s got=%b exp=0", bus.l_s); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        for (int c = 0; c < DW + 6; c++) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_late_done cycle=%0d got=%b exp=0", c, bus.done); end
        end
        run_mult(16'd11, 16'd13, "post_rst");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.multiplier = '0;
        bus.multiplicand = '0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_early_exit();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=stalled exp=finish");
        $fatal(1, "timeout");
    end
endmodule
